// File: rtl/fsm_escribir_rtc.sv
// Writes date/time registers to a multiplexed-AD-bus RTC, then issues the 0xF1 command.
// Define RTC_WR_TIMER_EN to also write the timer registers 0x41-0x43.
module fsm_escribir_rtc #(
  parameter int T_PULSE = 10,
  parameter int T_GAP   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       do_it_escribir,
  input  logic [7:0] seg,
  input  logic [7:0] min,
  input  logic [7:0] hora,
  input  logic [7:0] dia,
  input  logic [7:0] mes,
  input  logic [7:0] anio,
  input  logic [7:0] seg_tim,
  input  logic [7:0] min_tim,
  input  logic [7:0] hora_tim,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] dato_out,
  output logic       bus_oe,
  output logic       busy,
  output logic       done
);

`ifdef RTC_WR_TIMER_EN
  localparam int N_DATA = 9;
`else
  localparam int N_DATA = 6;
`endif
  localparam int N_TXN = N_DATA + 1;
  localparam logic [3:0] LAST_IDX   = 4'(N_TXN - 1);
  localparam logic [5:0] PULSE_LOAD = 6'(T_PULSE - 1);
  localparam logic [5:0] GAP_LOAD   = 6'(T_GAP - 1);

  localparam logic [3:0] IDLE        = 4'd0;
  localparam logic [3:0] ADDR_SETUP  = 4'd1;
  localparam logic [3:0] ADDR_STROBE = 4'd2;
  localparam logic [3:0] ADDR_HOLD   = 4'd3;
  localparam logic [3:0] ADDR_GAP    = 4'd4;
  localparam logic [3:0] DATA_SETUP  = 4'd5;
  localparam logic [3:0] DATA_STROBE = 4'd6;
  localparam logic [3:0] DATA_HOLD   = 4'd7;
  localparam logic [3:0] DATA_GAP    = 4'd8;
  localparam logic [3:0] DONE        = 4'd9;

  logic [3:0] state_reg, state_next;
  logic [5:0] cnt_reg, cnt_next;
  logic [3:0] idx_reg, idx_next;
  logic       snap_load;
  logic [7:0] snap_in  [N_DATA];
  logic [7:0] snap_reg [N_DATA];
  logic [7:0] data_sel;

  assign snap_in[0] = seg;
  assign snap_in[1] = min;
  assign snap_in[2] = hora;
  assign snap_in[3] = dia;
  assign snap_in[4] = mes;
  assign snap_in[5] = anio;
`ifdef RTC_WR_TIMER_EN
  assign snap_in[6] = seg_tim;
  assign snap_in[7] = min_tim;
  assign snap_in[8] = hora_tim;
`else
  logic unused_tim;
  assign unused_tim = ^{seg_tim, min_tim, hora_tim};
`endif

  function automatic logic [7:0] addr_of(input logic [3:0] i);
    case (i)
      4'd0:    addr_of = 8'h21;
      4'd1:    addr_of = 8'h22;
      4'd2:    addr_of = 8'h23;
      4'd3:    addr_of = 8'h24;
      4'd4:    addr_of = 8'h25;
      4'd5:    addr_of = 8'h26;
`ifdef RTC_WR_TIMER_EN
      4'd6:    addr_of = 8'h41;
      4'd7:    addr_of = 8'h42;
      4'd8:    addr_of = 8'h43;
`endif
      default: addr_of = 8'hF1;
    endcase
  endfunction

  // The final command transaction has no snapshot; its data byte is 0x00.
  always_comb begin
    data_sel = 8'h00;
    for (int i = 0; i < N_DATA; i++) begin
      if (idx_reg == 4'(i)) data_sel = snap_reg[i];
    end
  end

  // Counter is reloaded on every transition; only STROBE and GAP count it down.
  always_comb begin
    state_next = state_reg;
    cnt_next   = 6'd0;
    idx_next   = idx_reg;
    snap_load  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (do_it_escribir) begin
          state_next = ADDR_SETUP;
          idx_next   = 4'd0;
          snap_load  = 1'b1;
        end
      end
      ADDR_SETUP: begin
        state_next = ADDR_STROBE;
        cnt_next   = PULSE_LOAD;
      end
      ADDR_STROBE: begin
        if (cnt_reg == 6'd0) state_next = ADDR_HOLD;
        else                 cnt_next   = cnt_reg - 6'd1;
      end
      ADDR_HOLD: begin
        if (T_GAP == 0) begin
          state_next = DATA_SETUP;
        end else begin
          state_next = ADDR_GAP;
          cnt_next   = GAP_LOAD;
        end
      end
      ADDR_GAP: begin
        if (cnt_reg == 6'd0) state_next = DATA_SETUP;
        else                 cnt_next   = cnt_reg - 6'd1;
      end
      DATA_SETUP: begin
        state_next = DATA_STROBE;
        cnt_next   = PULSE_LOAD;
      end
      DATA_STROBE: begin
        if (cnt_reg == 6'd0) state_next = DATA_HOLD;
        else                 cnt_next   = cnt_reg - 6'd1;
      end
      DATA_HOLD: begin
        if (T_GAP == 0) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            state_next = ADDR_SETUP;
            idx_next   = idx_reg + 4'd1;
          end
        end else begin
          state_next = DATA_GAP;
          cnt_next   = GAP_LOAD;
        end
      end
      DATA_GAP: begin
        if (cnt_reg != 6'd0) begin
          cnt_next = cnt_reg - 6'd1;
        end else if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end else begin
          state_next = ADDR_SETUP;
          idx_next   = idx_reg + 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 6'd0;
      idx_reg   <= 4'd0;
      for (int i = 0; i < N_DATA; i++) snap_reg[i] <= 8'h00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      if (snap_load) begin
        for (int i = 0; i < N_DATA; i++) snap_reg[i] <= snap_in[i];
      end
    end
  end

  // Bus controls decode directly from the registered state.
  always_comb begin
    cs       = 1'b1;
    wr       = 1'b1;
    a_d      = 1'b1;
    bus_oe   = 1'b0;
    dato_out = 8'h00;
    case (state_reg)
      ADDR_SETUP, ADDR_STROBE, ADDR_HOLD: begin
        cs       = 1'b0;
        a_d      = 1'b0;
        bus_oe   = 1'b1;
        dato_out = addr_of(idx_reg);
        wr       = (state_reg != ADDR_STROBE);
      end
      ADDR_GAP: a_d = 1'b0;
      DATA_SETUP, DATA_STROBE, DATA_HOLD: begin
        cs       = 1'b0;
        bus_oe   = 1'b1;
        dato_out = data_sel;
        wr       = (state_reg != DATA_STROBE);
      end
      default: ;
    endcase
  end

  assign rd   = 1'b1;
  assign done = (state_reg == DONE);
  assign busy = (state_reg != IDLE) && (state_reg != DONE);

endmodule

// File: tb/tb_fsm_escribir_rtc.sv
// Scoreboard bench for fsm_escribir_rtc: default-timing instance plus a T_PULSE=1/T_GAP=0 instance.
// Cycle counts treat the edge that samples the start request as cycle 1.
module tb_fsm_escribir_rtc;
`ifdef RTC_WR_TIMER_EN
  localparam int N = 10;
`else
  localparam int N = 7;
`endif
  localparam int TP = 10;
  localparam int TG = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, start_f;
  logic [7:0] seg, min, hora, dia, mes, anio, seg_tim, min_tim, hora_tim;
  logic       a_d, cs, rd, wr, bus_oe, busy, done;
  logic [7:0] dato_out;
  logic       a_d_f, cs_f, rd_f, wr_f, bus_oe_f, busy_f, done_f;
  logic [7:0] dato_out_f;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] sb_q[$];

  logic wr_prev = 1'b1;
  int   wr_low = 0;
  int   data_strobes = 0;
  logic fast_on = 1'b0;
  logic wr_f_prev = 1'b1;
  logic a_d_f_prev = 1'b1;
  int   f_wr_low = 0;
  int   f_ad_low = 0;
  int   f_strobes = 0;
  logic f_cs_high_busy = 1'b0;

  fsm_escribir_rtc dut (
    .clk(clk), .reset(reset), .do_it_escribir(start),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .seg_tim(seg_tim), .min_tim(min_tim), .hora_tim(hora_tim),
    .a_d(a_d), .cs(cs), .rd(rd), .wr(wr), .dato_out(dato_out),
    .bus_oe(bus_oe), .busy(busy), .done(done)
  );

  fsm_escribir_rtc #(.T_PULSE(1), .T_GAP(0)) dut_fast (
    .clk(clk), .reset(reset), .do_it_escribir(start_f),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .seg_tim(seg_tim), .min_tim(min_tim), .hora_tim(hora_tim),
    .a_d(a_d_f), .cs(cs_f), .rd(rd_f), .wr(wr_f), .dato_out(dato_out_f),
    .bus_oe(bus_oe_f), .busy(busy_f), .done(done_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected bus transactions, taken from the inputs at the moment start is driven.
  task automatic push_run();
    logic [7:0] addrs[$];
    logic [7:0] datas[$];
    addrs = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    datas = '{seg, min, hora, dia, mes, anio};
`ifdef RTC_WR_TIMER_EN
    addrs.push_back(8'h41); datas.push_back(seg_tim);
    addrs.push_back(8'h42); datas.push_back(min_tim);
    addrs.push_back(8'h43); datas.push_back(hora_tim);
`endif
    addrs.push_back(8'hF1); datas.push_back(8'h00);
    foreach (addrs[i]) begin
      sb_q.push_back({1'b0, addrs[i]});
      sb_q.push_back({1'b1, datas[i]});
    end
  endtask

  task automatic monitor();
    logic [8:0] exp;
    if (!wr && wr_prev) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        check("strobe_bus", {23'b0, a_d, dato_out}, {23'b0, exp});
        check("strobe_cs_oe_rd", {29'b0, cs, bus_oe, rd}, 3'b011);
      end
      if (a_d) data_strobes++;
      wr_low = 1;
    end else if (!wr) begin
      wr_low++;
    end else if (!wr_prev && !reset) begin
      check("wr_width", wr_low, TP);
    end
    wr_prev = wr;
    if (fast_on) begin
      if (busy_f && cs_f) f_cs_high_busy = 1'b1;
      if (!wr_f && wr_f_prev) begin f_strobes++; f_wr_low = 1; end
      else if (!wr_f) f_wr_low++;
      else if (!wr_f_prev) check("fast_wr_width", f_wr_low, 1);
      if (!a_d_f) f_ad_low++;
      else if (!a_d_f_prev) begin check("fast_addr_phase", f_ad_low, 3); f_ad_low = 0; end
    end
    wr_f_prev  = wr_f;
    a_d_f_prev = a_d_f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  initial begin
    int   n;
    logic saw_done, saw_strobe;
    reset = 1'b1; start = 1'b0; start_f = 1'b0;
    seg = 8'h00; min = 8'h00; hora = 8'h00; dia = 8'h00; mes = 8'h00; anio = 8'h00;
    seg_tim = 8'h00; min_tim = 8'h00; hora_tim = 8'h00;
    tick(); tick();
    check("rst_ctrl", {25'b0, cs, wr, rd, a_d, bus_oe, busy, done}, 7'b1111000);
    check("rst_dato", dato_out, 8'h00);
    check("rst_fast_ctrl", {25'b0, cs_f, wr_f, rd_f, a_d_f, bus_oe_f, busy_f, done_f}, 7'b1111000);
    reset = 1'b0;
    tick();

    // Nominal run; inputs change mid-run and a stray start pulse must be ignored.
    seg = 8'h45; min = 8'h30; hora = 8'h23; dia = 8'h15; mes = 8'h06; anio = 8'h24;
    seg_tim = 8'h05; min_tim = 8'h10; hora_tim = 8'h12;
    push_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    check("busy_after_start", {30'b0, busy, a_d}, 2'b10);
    while (!done && n < 2000) begin
      start = (n == 50);
      if (n == 80) begin
        seg = 8'h59; min = 8'h01; anio = 8'h99; hora_tim = 8'h77;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("done_cycle", n, N * 2 * (TP + 2 + TG) + 1);
    check("done_busy", {30'b0, done, busy}, 2'b10);
    check("sb_drained", sb_q.size(), 0);
    tick();
    check("done_one_cycle", {30'b0, done, busy}, 2'b00);

    // Held start: retrigger exactly two cycles after done, then abort by reset.
    seg = 8'h45; min = 8'h30; anio = 8'h24; hora_tim = 8'h12;
    push_run();
    start = 1'b1;
    tick();
    n = 1;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
    check("done_cycle_held", n, N * 2 * (TP + 2 + TG) + 1);
    check("sb_drained_held", sb_q.size(), 0);
    tick();
    check("held_idle", {30'b0, busy, done}, 2'b00);
    push_run();
    tick();
    check("retrigger_setup", {29'b0, cs, a_d, busy}, 3'b001);
    start = 1'b0;
    data_strobes = 0;
    n = 0;
    while (data_strobes < 4 && n < 1000) begin
      tick();
      n++;
    end
    check("reach_4th_data", data_strobes, 4);
    reset = 1'b1;
    tick();
    check("abort_ctrl", {28'b0, wr, cs, bus_oe, busy}, 4'b1100);
    reset = 1'b0;
    sb_q.delete();
    saw_done = 1'b0;
    saw_strobe = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done) saw_done = 1'b1;
      if (!wr) saw_strobe = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_no_strobe", saw_strobe, 0);

    // Minimum timing instance.
    fast_on = 1'b1;
    start_f = 1'b1;
    tick();
    start_f = 1'b0;
    n = 1;
    while (!done_f && n < 2000) begin
      tick();
      n++;
    end
    check("fast_done_cycle", n, N * 6 + 1);
    check("fast_cs_low", f_cs_high_busy, 0);
    check("fast_strobes", f_strobes, 2 * N);
    tick();
    fast_on = 1'b0;
    check("fast_idle", {30'b0, busy_f, done_f}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
